// File: rtl/en_conditioner.sv
// rtl/en_conditioner.sv - synchroniser, two-edge debouncer and auto-repeat enable pulse generator
// Turns a raw button line into one-cycle en pulses for the downstream decade counter.
module en_conditioner #(
  parameter int DB_CYCLES  = 4,
  parameter int RPT_DELAY  = 20,
  parameter int RPT_PERIOD = 10,
  parameter int TMR_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic rpt_en,
  output logic en,
  output logic btn_level,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] DB_LAST    = TMR_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(RPT_DELAY - 1);
  localparam logic [TMR_W-1:0] RPT_LAST   = TMR_W'(RPT_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  logic             s1_q;
  logic             btn_s_q;
  state_t           state_q;
  state_t           state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic             en_q;
  logic             en_d;
  logic             btn_level_q;
  logic             btn_level_d;
  logic             held_q;
  logic             held_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      btn_s_q     <= 1'b0;
      state_q     <= IDLE;
      timer_q     <= '0;
      en_q        <= 1'b0;
      btn_level_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      s1_q        <= btn_in;
      btn_s_q     <= s1_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      en_q        <= en_d;
      btn_level_q <= btn_level_d;
      held_q      <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (btn_s_q) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s_q)               state_d = IDLE;
        else if (timer_q == DB_LAST) state_d = PRESSED;
        else                         timer_d = timer_q + TMR_ONE;
      end
      PRESSED: begin
        // Timer parks at the last delay count so a late rpt_en fires on the next edge.
        if (!btn_s_q) begin
          state_d = DB_RELEASE;
        end else if (timer_q == DELAY_LAST) begin
          if (rpt_en) state_d = REPEAT;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      REPEAT: begin
        if (!btn_s_q)                 state_d = DB_RELEASE;
        else if (!rpt_en)             state_d = PRESSED;
        else if (timer_q == RPT_LAST) timer_d = '0;
        else                          timer_d = timer_q + TMR_ONE;
      end
      DB_RELEASE: begin
        if (btn_s_q)                 state_d = PRESSED;
        else if (timer_q == DB_LAST) state_d = IDLE;
        else                         timer_d = timer_q + TMR_ONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_comb begin
    en_d = 1'b0;
    if (state_q == DB_PRESS && state_d == PRESSED) en_d = 1'b1;
    if (state_q == PRESSED && state_d == REPEAT) en_d = 1'b1;
    if (state_q == REPEAT && state_d == REPEAT && timer_q == RPT_LAST) en_d = 1'b1;
    btn_level_d = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == DB_RELEASE);
    held_d      = (state_d == REPEAT);
  end

  assign en        = en_q;
  assign btn_level = btn_level_q;
  assign held      = held_q;

endmodule

// File: tb/tb_en_conditioner.sv
// tb/tb_en_conditioner.sv - directed bench for en_conditioner with a pulse-time scoreboard
// Expected en edges are queued as stimulus is driven and popped by the monitor.
module tb_en_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 10;
  localparam int LAT = 3 + DB;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic rpt_en;
  logic en;
  logic btn_level;
  logic held;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  logic prev_en = 1'b0;
  logic prev_lvl = 1'b0;
  int lvl_rises = 0;
  logic [3:0] cnt;
  logic tc;

  always #5 clk = ~clk;

  en_conditioner #(
    .DB_CYCLES(DB),
    .RPT_DELAY(RD),
    .RPT_PERIOD(RP),
    .TMR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .rpt_en(rpt_en),
    .en(en),
    .btn_level(btn_level),
    .held(held)
  );

  // Reference decade counter driven by en.
  always @(posedge clk or posedge rst) begin
    if (rst)       cnt <= 4'd0;
    else if (en)   cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  end
  assign tc = (cnt == 4'd9);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always begin
    int e;
    @(posedge clk);
    cyc++;
    #1;
    if (en === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("en_time", cyc, e);
      chk("en_back_to_back", {31'd0, prev_en}, 0);
    end
    if (btn_level === 1'b1 && prev_lvl === 1'b0) lvl_rises++;
    prev_en  = en;
    prev_lvl = btn_level;
  end

  initial begin
    int s;
    int r0;
    rst = 1'b1;
    btn_in = 1'b0;
    rpt_en = 1'b0;
    @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_held", held, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(cyc + 3);

    // Clean press, no repeat.
    s = cyc;
    btn_in = 1'b1;
    exp_q.push_back(s + LAT);
    wait_cyc(s + LAT - 1);
    chk("t1_level_before", btn_level, 0);
    wait_cyc(s + LAT);
    chk("t1_level_rise", btn_level, 1);
    chk("t1_held", held, 0);
    wait_cyc(s + 30);
    chk("t1_held_late", held, 0);
    btn_in = 1'b0;
    wait_cyc(s + 30 + LAT - 1);
    chk("t1_level_hold", btn_level, 1);
    wait_cyc(s + 30 + LAT);
    chk("t1_level_fall", btn_level, 0);
    wait_cyc(s + 45);
    chk("t1_queue", exp_q.size(), 0);

    // Glitch of 3 cycles.
    s = cyc;
    btn_in = 1'b1;
    wait_cyc(s + 3);
    btn_in = 1'b0;
    wait_cyc(s + 12);
    chk("t2_level", btn_level, 0);
    chk("t2_queue", exp_q.size(), 0);

    // Bouncy press then bouncy release.
    s = cyc;
    r0 = lvl_rises;
    btn_in = 1'b1; wait_cyc(s + 1);
    btn_in = 1'b0; wait_cyc(s + 2);
    btn_in = 1'b1; wait_cyc(s + 3);
    btn_in = 1'b0; wait_cyc(s + 4);
    btn_in = 1'b1;
    exp_q.push_back(s + 4 + LAT);
    wait_cyc(s + 4 + LAT - 1);
    chk("t3_level_before", btn_level, 0);
    wait_cyc(s + 25);
    btn_in = 1'b0; wait_cyc(s + 26);
    btn_in = 1'b1; wait_cyc(s + 27);
    btn_in = 1'b0;
    wait_cyc(s + 29);
    chk("t3_level_bounce", btn_level, 1);
    wait_cyc(s + 33);
    chk("t3_level_hold", btn_level, 1);
    wait_cyc(s + 34);
    chk("t3_level_fall", btn_level, 0);
    wait_cyc(s + 40);
    chk("t3_single_interval", lvl_rises - r0, 1);
    chk("t3_queue", exp_q.size(), 0);

    // Auto-repeat held for 60 cycles.
    rpt_en = 1'b1;
    s = cyc;
    btn_in = 1'b1;
    exp_q.push_back(s + LAT);
    for (int t = s + LAT + RD; t < s + 60 + 3; t += RP) exp_q.push_back(t);
    wait_cyc(s + LAT + RD - 1);
    chk("t4_held_before", held, 0);
    wait_cyc(s + LAT + RD);
    chk("t4_held_rise", held, 1);
    wait_cyc(s + 60);
    btn_in = 1'b0;
    wait_cyc(s + 62);
    chk("t4_held_hold", held, 1);
    wait_cyc(s + 63);
    chk("t4_held_fall", held, 0);
    chk("t4_level_hold", btn_level, 1);
    wait_cyc(s + 67);
    chk("t4_level_fall", btn_level, 0);
    wait_cyc(s + 75);
    chk("t4_queue", exp_q.size(), 0);

    // Auto-repeat with rpt_en dropped 35 cycles after the first pulse.
    s = cyc;
    btn_in = 1'b1;
    exp_q.push_back(s + LAT);
    exp_q.push_back(s + LAT + RD);
    exp_q.push_back(s + LAT + RD + RP);
    wait_cyc(s + LAT + 35);
    chk("t4b_held_on", held, 1);
    rpt_en = 1'b0;
    wait_cyc(s + LAT + 36);
    chk("t4b_held_off", held, 0);
    chk("t4b_level", btn_level, 1);
    wait_cyc(s + 60);
    btn_in = 1'b0;
    wait_cyc(s + 75);
    chk("t4b_queue", exp_q.size(), 0);

    // Reset during REPEAT with the button still held.
    rpt_en = 1'b1;
    s = cyc;
    btn_in = 1'b1;
    exp_q.push_back(s + LAT);
    exp_q.push_back(s + LAT + RD);
    exp_q.push_back(s + LAT + RD + RP);
    wait_cyc(s + LAT + RD + RP);
    chk("t5_pre_held", held, 1);
    rst = 1'b1;
    #1;
    chk("t5_async_en", en, 0);
    chk("t5_async_held", held, 0);
    chk("t5_async_level", btn_level, 0);
    wait_cyc(s + LAT + RD + RP + 2);
    rst = 1'b0;
    rpt_en = 1'b0;
    exp_q.push_back(cyc + LAT);
    wait_cyc(cyc + LAT - 1);
    chk("t5_level_before", btn_level, 0);
    wait_cyc(cyc + 1);
    chk("t5_level_after", btn_level, 1);
    wait_cyc(cyc + 3);
    btn_in = 1'b0;
    wait_cyc(cyc + 15);
    chk("t5_queue", exp_q.size(), 0);

    // Twelve presses into the decade counter.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(cyc + 2);
    for (int k = 1; k <= 12; k++) begin
      s = cyc;
      btn_in = 1'b1;
      exp_q.push_back(s + LAT);
      wait_cyc(s + LAT + 1);
      chk($sformatf("t6_count_%0d", k), cnt, k % 10);
      chk($sformatf("t6_tc_%0d", k), tc, (k % 10 == 9) ? 1 : 0);
      wait_cyc(s + 10);
      btn_in = 1'b0;
      wait_cyc(s + 22);
    end
    chk("t6_queue", exp_q.size(), 0);

    wait_cyc(cyc + 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
